mem_port_arbiter: RTL

- Shares the single-ported data/instruction memory between the fetch unit (IF) and the load/store unit (LSU).
- Grants one requester at a time, registers its address, write data and controls, and runs a valid/ready transaction to memory.
- Returns read data and a one-cycle ack to the owner.
- Drives `sel_lsu` to the core's 2:1 operand/address muxes and produces stall signals for the pipeline.

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the load/store unit.
// One registered valid/ready transaction at a time, with an IF starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [3:0]        lsu_be,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_ack,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              sel_lsu,
  output logic              if_stall,
  output logic              lsu_stall
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             any_req;
  logic             starved;
  logic             grant_lsu;

  // LSU wins ties unless IF has been passed over STARVE_LIMIT times in a row.
  always_comb begin
    any_req   = if_req | lsu_req;
    starved   = if_req & (starve_cnt == STARVE_MAX);
    grant_lsu = lsu_req & ~starved;
    if_stall  = if_req & ~if_ack;
    lsu_stall = lsu_req & ~lsu_ack;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (mem_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'h0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      lsu_ack    <= 1'b0;
      if_rdata   <= '0;
      lsu_rdata  <= '0;
      sel_lsu    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if_ack  <= 1'b0;
      lsu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            sel_lsu   <= grant_lsu;
            mem_valid <= 1'b1;
            if (grant_lsu) begin
              mem_addr  <= lsu_addr;
              mem_wdata <= lsu_wdata;
              mem_we    <= lsu_we;
              mem_be    <= lsu_be;
              if (if_req && (starve_cnt != STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;
            end else begin
              mem_addr   <= if_addr;
              mem_wdata  <= '0;
              mem_we     <= 1'b0;
              mem_be     <= 4'hF;
              starve_cnt <= '0;
            end
          end
        end
        BUSY: begin
          // Stores still ack but leave the LSU's last load data untouched.
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (sel_lsu) begin
              lsu_ack <= 1'b1;
              if (!mem_we) lsu_rdata <= mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
